// File: rtl/sdram_rw_arbiter.sv
// sdram_rw_arbiter: schedules SDRAM bursts between the camera write FIFO and
// the LCD read FIFO. It generates each burst's start address and length,
// walks the frame pointers with wrap, and flips banks for ping-pong buffering.
module sdram_rw_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int LEN_W    = 10,
  parameter int BANK_BIT = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [LEN_W-1:0]  wr_level,
  input  logic [LEN_W-1:0]  rd_level,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              read_valid,
  input  logic              pingpang_en,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_burst,
  input  logic              wr_ack,
  input  logic              wr_done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_burst,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

  state_t              state_q, state_d;
  logic                last_rd_q, last_rd_d;   // 1: last grant went to the read port
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic                wr_lp_q, wr_lp_d, rd_lp_q, rd_lp_d;  // deferred load flags
  logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q;
  logic [LEN_W-1:0]    wr_burst_q, rd_burst_q;
  logic                grant_wr, grant_rd;
  logic                wr_pend, rd_pend;
  logic [ADDR_W:0]     wr_next, rd_next;

  // Replace the bank bit with the port's bank when ping-pong is enabled.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [ADDR_W-1:0] p,
                                                  input logic b, input logic en);
    logic [ADDR_W-1:0] a;
    a = p;
    if (en) a[BANK_BIT] = b;
    return a;
  endfunction

  // A port with a deferred load is held off until the reload lands in IDLE.
  assign wr_pend = init_done & ~wr_load & ~wr_lp_q & (wr_level >= wr_len);
  assign rd_pend = init_done & read_valid & ~rd_load & ~rd_lp_q & (rd_level < rd_len);

  // Arbitration and handshake sequencing.
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_pend && (!rd_pend || last_rd_q)) begin
          grant_wr  = 1'b1;
          last_rd_d = 1'b0;
          state_d   = WR_REQ;
        end else if (rd_pend) begin
          grant_rd  = 1'b1;
          last_rd_d = 1'b1;
          state_d   = RD_REQ;
        end
      end
      WR_REQ:  if (wr_ack)  state_d = WR_WAIT;
      WR_WAIT: if (wr_done) state_d = IDLE;
      RD_REQ:  if (rd_ack)  state_d = RD_WAIT;
      RD_WAIT: if (rd_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer / bank / deferred-load bookkeeping. The write side is resolved
  // first so a read wrap sees the post-toggle write bank.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    wr_lp_d   = wr_lp_q;
    rd_ptr_d  = rd_ptr_q;
    rd_bank_d = rd_bank_q;
    rd_lp_d   = rd_lp_q;
    wr_next   = {1'b0, wr_ptr_q} + (ADDR_W+1)'(wr_burst_q);
    rd_next   = {1'b0, rd_ptr_q} + (ADDR_W+1)'(rd_burst_q);

    if (state_q == IDLE) begin
      if (wr_load || wr_lp_q) begin
        wr_ptr_d  = wr_min_addr;
        wr_bank_d = 1'b0;
        wr_lp_d   = 1'b0;
      end
    end else if (state_q == WR_WAIT && wr_done) begin
      wr_lp_d = 1'b0;
      if (wr_load || wr_lp_q) begin
        wr_ptr_d  = wr_min_addr;
        wr_bank_d = 1'b0;
      end else if (wr_next >= {1'b0, wr_max_addr}) begin
        wr_ptr_d = wr_min_addr;
        if (pingpang_en) wr_bank_d = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_next[ADDR_W-1:0];
      end
    end else if (wr_load) begin
      wr_lp_d = 1'b1;
    end

    if (state_q == IDLE) begin
      if (rd_load || rd_lp_q) begin
        rd_ptr_d  = rd_min_addr;
        rd_bank_d = 1'b1;
        rd_lp_d   = 1'b0;
      end
    end else if (state_q == RD_WAIT && rd_done) begin
      rd_lp_d = 1'b0;
      if (rd_load || rd_lp_q) begin
        rd_ptr_d  = rd_min_addr;
        rd_bank_d = 1'b1;
      end else if (rd_next >= {1'b0, rd_max_addr}) begin
        rd_ptr_d = rd_min_addr;
        if (pingpang_en) rd_bank_d = ~wr_bank_d;
      end else begin
        rd_ptr_d = rd_next[ADDR_W-1:0];
      end
    end else if (rd_load) begin
      rd_lp_d = 1'b1;
    end
  end

  // State, pointers and burst descriptors captured at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_rd_q  <= 1'b1;
      wr_ptr_q   <= wr_min_addr;
      rd_ptr_q   <= rd_min_addr;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b1;
      wr_lp_q    <= 1'b0;
      rd_lp_q    <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_burst_q <= '0;
      rd_burst_q <= '0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_lp_q   <= wr_lp_d;
      rd_lp_q   <= rd_lp_d;
      if (grant_wr) begin
        wr_addr_q  <= bank_addr(wr_ptr_q, wr_bank_q, pingpang_en);
        wr_burst_q <= wr_len;
      end
      if (grant_rd) begin
        rd_addr_q  <= bank_addr(rd_ptr_q, rd_bank_q, pingpang_en);
        rd_burst_q <= rd_len;
      end
    end
  end

  assign wr_req   = (state_q == WR_REQ);
  assign rd_req   = (state_q == RD_REQ);
  assign wr_addr  = wr_addr_q;
  assign rd_addr  = rd_addr_q;
  assign wr_burst = wr_burst_q;
  assign rd_burst = rd_burst_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Bench for sdram_rw_arbiter: plays the SDRAM controller with random ack/done
// delays and stray pulses, and predicts grants/addresses from a frame model.
module tb_sdram_rw_arbiter;
  localparam int AW = 24, LW = 10, BB = 22;

  logic          clk = 1'b0, rst = 1'b1, init_done = 1'b0;
  logic [LW-1:0] wr_level = '0, rd_level = '0, wr_len = 10'd512, rd_len = 10'd512;
  logic [AW-1:0] wr_min_addr = '0, wr_max_addr = 24'd1024;
  logic [AW-1:0] rd_min_addr = '0, rd_max_addr = 24'd1024;
  logic          wr_load = 0, rd_load = 0, read_valid = 0, pingpang_en = 0;
  logic          wr_req, rd_req, busy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [LW-1:0] wr_burst, rd_burst;
  logic          wr_ack = 0, wr_done = 0, rd_ack = 0, rd_done = 0;

  always #5 clk = ~clk;

  sdram_rw_arbiter #(.ADDR_W(AW), .LEN_W(LW), .BANK_BIT(BB)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_level(wr_level), .rd_level(rd_level), .wr_len(wr_len), .rd_len(rd_len),
    .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr),
    .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr),
    .wr_load(wr_load), .rd_load(rd_load), .read_valid(read_valid), .pingpang_en(pingpang_en),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_burst(wr_burst), .wr_ack(wr_ack), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_burst(rd_burst), .rd_ack(rd_ack), .rd_done(rd_done),
    .busy(busy)
  );

  int vectors = 0, errs = 0;
  // Frame model: pointers, banks, who was granted last.
  int m_wr_ptr, m_rd_ptr;
  bit m_wr_bank, m_rd_bank, m_last_rd;
  logic [31:0] last_wr_addr, last_rd_addr;

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_ptr = int'(wr_min_addr); m_rd_ptr = int'(rd_min_addr);
    m_wr_bank = 0; m_rd_bank = 1; m_last_rd = 1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0; model_reset();
  endtask

  function automatic logic [31:0] mk_addr(input int p, input bit b);
    if (!pingpang_en) return 32'(p);
    return 32'((p & ~(1 << BB)) | (int'(b) << BB));
  endfunction

  // One full burst. imm: req must appear on the first cycle (one IDLE gap).
  // load_mode: 0 none, 1 wr_load pulse in WAIT, 2 wr_load with wr_done.
  task automatic burst(input bit imm, input int load_mode);
    int n, d, elen; bit wp, rp, isrd, act; logic [31:0] ea;
    wp = init_done && !wr_load && (wr_level >= wr_len);
    rp = init_done && read_valid && !rd_load && (rd_level < rd_len);
    isrd = (wp && rp) ? !m_last_rd : rp;
    n = 0;
    do begin tick(); n++; end while (!(wr_req || rd_req) && n < 200);
    chk("req_seen", 32'(wr_req | rd_req), 1);
    if (!(wr_req || rd_req)) return;
    if (imm) chk("idle_gap", n, 1);
    act = rd_req;
    chk("grant_rd", 32'(rd_req), 32'(isrd));
    chk("single_req", 32'(wr_req & rd_req), 0);
    m_last_rd = isrd;
    ea   = isrd ? mk_addr(m_rd_ptr, m_rd_bank) : mk_addr(m_wr_ptr, m_wr_bank);
    elen = isrd ? int'(rd_len) : int'(wr_len);
    chk("addr", act ? 32'(rd_addr) : 32'(wr_addr), ea);
    chk("burst", act ? 32'(rd_burst) : 32'(wr_burst), 32'(elen));
    d = $urandom_range(0, 3);
    repeat (d) begin
      if (act) wr_ack = 1'($urandom_range(0, 1)); else rd_ack = 1'($urandom_range(0, 1));
      tick();
      chk("req_hold", act ? 32'(rd_req) : 32'(wr_req), 1);
      chk("addr_hold", act ? 32'(rd_addr) : 32'(wr_addr), ea);
    end
    wr_ack = 0; rd_ack = 0;
    if (act) rd_ack = 1; else wr_ack = 1;
    tick(); wr_ack = 0; rd_ack = 0;
    chk("req_drop", 32'(wr_req | rd_req), 0);
    chk("busy_wait", 32'(busy), 1);
    if (load_mode == 1) begin wr_load = 1; tick(); wr_load = 0; end
    d = $urandom_range(0, 4);
    repeat (d) begin
      if (act) wr_done = 1'($urandom_range(0, 1)); else rd_done = 1'($urandom_range(0, 1));
      tick();
      chk("busy_wait", 32'(busy), 1);
    end
    wr_done = 0; rd_done = 0;
    if (act) rd_done = 1; else wr_done = 1;
    if (load_mode == 2) wr_load = 1;
    tick(); wr_done = 0; rd_done = 0; wr_load = 0;
    chk("busy_idle", 32'(busy), 0);
    if (isrd) begin
      last_rd_addr = 32'(rd_addr);
      if (m_rd_ptr + elen >= int'(rd_max_addr)) begin
        m_rd_ptr = int'(rd_min_addr);
        if (pingpang_en) m_rd_bank = !m_wr_bank;
      end else m_rd_ptr += elen;
    end else begin
      last_wr_addr = 32'(wr_addr);
      if (load_mode != 0) begin
        m_wr_ptr = int'(wr_min_addr); m_wr_bank = 0;
      end else if (m_wr_ptr + elen >= int'(wr_max_addr)) begin
        m_wr_ptr = int'(wr_min_addr);
        if (pingpang_en) m_wr_bank = !m_wr_bank;
      end else m_wr_ptr += elen;
    end
  endtask

  initial begin
    int seen;
    // Reset state
    tick(); tick(); rst = 0; model_reset();
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_busy", 32'(busy), 0);

    // Write only, ping-pong on: 0, 512, then wrap to 0 with bank bit set
    pingpang_en = 1; wr_level = 10'd512; wr_len = 10'd512; init_done = 1;
    burst(0, 0);
    chk("first_wr_addr", last_wr_addr, 0);
    burst(1, 0);
    chk("second_wr_addr", last_wr_addr, 512);
    burst(1, 0);
    chk("third_wr_addr", last_wr_addr, 32'h400000);

    // Round robin with random lengths and ping-pong setting
    do_reset();
    read_valid = 1; rd_level = '0;
    pingpang_en = 1'($urandom_range(0, 1));
    wr_len = 10'($urandom_range(1, 512)); rd_len = 10'($urandom_range(1, 512));
    burst(0, 0);
    chk("rr_first_is_wr", last_wr_addr, mk_addr(0, 0));
    for (int i = 0; i < 11; i++) burst(1, 0);

    // Ping-pong read takes the last complete frame
    do_reset();
    pingpang_en = 1; wr_len = 10'd512; rd_len = 10'd512;
    burst(0, 0);
    for (int i = 0; i < 5; i++) burst(1, 0);
    chk("pp_rd_bank0", last_rd_addr, 0);
    pingpang_en = 0;
    burst(1, 0); burst(1, 0);
    chk("nopp_rd_addr", last_rd_addr, 512);

    // Load during a burst and with done
    do_reset();
    read_valid = 0; pingpang_en = 0; wr_len = 10'd512;
    burst(0, 0);
    burst(1, 1);
    chk("load_mid_wr", last_wr_addr, 512);
    burst(1, 0);
    chk("after_load_mid", last_wr_addr, 0);
    burst(1, 2);
    burst(1, 0);
    chk("after_load_done", last_wr_addr, 0);
    // Load in IDLE to a new window
    wr_load = 1; wr_min_addr = 24'd2048; wr_max_addr = 24'd4096;
    seen = 0;
    repeat (5) begin tick(); if (wr_req || rd_req) seen++; end
    chk("idle_load_noreq", seen, 0);
    wr_load = 0; m_wr_ptr = 2048; m_wr_bank = 0;
    burst(0, 0);
    chk("idle_load_addr", last_wr_addr, 2048);

    // Gating: init_done low with both ports pending
    read_valid = 1; rd_level = '0; rd_len = 10'd100; init_done = 0;
    seen = 0;
    repeat (100) begin tick(); if (wr_req || rd_req) seen++; end
    chk("init_gate", seen, 0);
    init_done = 1; read_valid = 0;
    burst(0, 0);
    for (int i = 0; i < 3; i++) burst(1, 0);

    // Reset while a read request is outstanding
    do_reset();
    wr_level = '0; read_valid = 1; rd_len = 10'd256;
    burst(0, 0);
    seen = 0;
    while (!rd_req && seen < 50) begin tick(); seen++; end
    chk("rd_req_before_rst", 32'(rd_req), 1);
    rst = 1; read_valid = 0; tick(); rst = 0; model_reset();
    chk("rst_mid_rd_req", 32'(rd_req), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    rd_ack = 1; tick(); rd_ack = 0; tick();
    chk("stray_ack_busy", 32'(busy), 0);
    chk("stray_ack_req", 32'(rd_req), 0);
    read_valid = 1;
    burst(0, 0);
    chk("rd_ptr_at_min", last_rd_addr, 32'(rd_min_addr));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
